// File: rtl/progmem_loader.sv
// Program memory loader: assembles a little-endian byte stream into instruction words,
// holds the core disabled while loading, and serves instructions to the core otherwise.
module progmem_loader #(
    parameter int unsigned         INST_W = 32,
    parameter int unsigned         ADDR_W = 8,
    parameter logic [INST_W-1:0]   NOP    = INST_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_done,
    output logic              en,
    input  logic [ADDR_W-1:0] progmem_addr,
    output logic [INST_W-1:0] progmem_data
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam int unsigned       BYTES     = INST_W / 8;
    localparam int unsigned       BIDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   wptr_q;
    logic [BIDX_W-1:0]   bidx_q;
    logic [INST_W-1:0]   buf_q;
    logic                done_q;

    logic [INST_W-1:0]   mem [DEPTH];

    logic                start;
    logic                accept;
    logic                word_done;
    logic                last_word;
    logic [ADDR_W:0]     wcount;
    logic [ADDR_W:0]     len_clamped;
    logic [INST_W-1:0]   asm_word;

    assign start     = load_start && (state_q != StLoad);
    assign accept    = load_valid && (state_q == StLoad);
    assign word_done = accept && (bidx_q == LAST_BIDX);
    // Number of words complete once the current word is written.
    assign wcount    = {1'b0, wptr_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word = (wcount == len_q);

    // Zero length and oversize lengths both mean "fill the whole memory".
    always_comb begin
        len_clamped = load_len;
        if (load_len == '0 || load_len > DEPTH_LEN) begin
            len_clamped = DEPTH_LEN;
        end
    end

    always_comb begin
        asm_word = buf_q;
        for (int i = 0; i < BYTES; i++) begin
            if (bidx_q == BIDX_W'(i)) begin
                asm_word[8*i +: 8] = load_data;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (load_start) state_d = StLoad;
            StLoad: if (word_done && last_word) state_d = StRun;
            StRun:  if (load_start) state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        en           = (state_q == StRun);
        load_ready   = (state_q == StLoad);
        load_done    = done_q;
        progmem_data = (state_q == StLoad) ? NOP : mem[progmem_addr];
    end

    // Load datapath; the partial word is discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            wptr_q <= '0;
            bidx_q <= '0;
            buf_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= word_done && last_word;
            if (start) begin
                len_q  <= len_clamped;
                wptr_q <= '0;
                bidx_q <= '0;
            end else if (accept) begin
                buf_q  <= asm_word;
                bidx_q <= (bidx_q == LAST_BIDX) ? '0 : bidx_q + BIDX_W'(1);
                if (word_done) begin
                    wptr_q <= wptr_q + ADDR_W'(1);
                end
            end
        end
    end

    // Memory is deliberately not reset so a reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (word_done) begin
            mem[wptr_q] <= asm_word;
        end
    end

endmodule

// File: tb/tb_progmem_loader.sv
// Directed bench for progmem_loader: table-driven load sequences plus hand-written
// reset, clamp and full-depth scenarios.
module tb_progmem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [8:0]  load_len;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic        load_done;
    logic        en;
    logic [7:0]  progmem_addr;
    logic [31:0] progmem_data;

    int n_cmp;
    int n_err;

    progmem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_len     (load_len),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_done    (load_done),
        .en           (en),
        .progmem_addr (progmem_addr),
        .progmem_data (progmem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [8:0]  len;
        logic        valid;
        logic [7:0]  data;
        logic [7:0]  addr;
        logic        exp_ready;
        logic        exp_en;
        logic        exp_done;
        logic        chk_pd;
        logic [31:0] exp_pd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [8:0] l, input logic v, input logic [7:0] d,
                       input logic [7:0] a, input logic r, input logic e, input logic dn,
                       input logic c, input logic [31:0] pd);
        vec_t t;
        t.start = s; t.len = l; t.valid = v; t.data = d; t.addr = a;
        t.exp_ready = r; t.exp_en = e; t.exp_done = dn; t.chk_pd = c; t.exp_pd = pd;
        vecs.push_back(t);
    endtask

    task automatic drive_idle();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
    endtask

    function automatic logic [7:0] pat(input int w, input int b, input logic [7:0] seed);
        logic [7:0] x;
        x = w[7:0] ^ seed;
        case (b)
            0: return x;
            1: return x ^ 8'h5A;
            2: return 8'hC3 ^ seed;
            default: return ~x;
        endcase
    endfunction

    // Fills all 256 words; optionally pokes load_start mid-load, which must be ignored.
    task automatic full_load(input logic [8:0] len, input logic [7:0] seed, input bit poke,
                             input string tag);
        int bad;
        @(negedge clk);
        load_start = 1'b1; load_len = len; load_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            load_start = poke && (i == 100);
            load_len   = 9'd1;
            load_valid = 1'b1;
            load_data  = pat(i / 4, i % 4, seed);
            progmem_addr = 8'(i);
            #1;
            if (load_ready !== 1'b1 || load_done !== 1'b0 || en !== 1'b0 ||
                progmem_data !== NOP) bad++;
        end
        chk({tag, " bad load cycles"}, 32'(bad), 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        chk({tag, " done after last byte"}, 32'(load_done), 32'd1);
        chk({tag, " en after last byte"}, 32'(en), 32'd1);
        @(negedge clk);
        #1;
        chk({tag, " done single pulse"}, 32'(load_done), 32'd0);
        bad = 0;
        for (int w = 0; w < 256; w++) begin
            progmem_addr = 8'(w);
            #1;
            if (progmem_data !== {pat(w, 3, seed), pat(w, 2, seed), pat(w, 1, seed),
                                  pat(w, 0, seed)}) bad++;
        end
        chk({tag, " readback errors"}, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [7:0] ba [8];
        logic [7:0] bc [4];
        logic [7:0] bm [5];
        logic [7:0] br [4];
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        load_len = 9'd0;
        progmem_addr = 8'd0;
        drive_idle();

        ba = '{8'h13, 8'h01, 8'h20, 8'h00, 8'h13, 8'h02, 8'h30, 8'h00};
        bc = '{8'h93, 8'h00, 8'h50, 8'h00};

        // Basic load from IDLE
        add(1, 9'd2, 0, 8'h00, 8'd0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++) add(0, 9'd0, 1, ba[i], 8'd0, 1, 0, 0, 1, NOP);
        add(0, 9'd0, 0, 8'h00, 8'd0, 0, 1, 1, 1, 32'h0020_0113);
        add(0, 9'd0, 0, 8'h00, 8'd1, 0, 1, 0, 1, 32'h0030_0213);
        // Gapped reload from RUN, with an ignored load_start in the middle
        add(1, 9'd2, 0, 8'h00, 8'd1, 0, 1, 0, 1, 32'h0030_0213);
        for (int i = 0; i < 8; i++) begin
            add(i == 3, 9'd1, 0, 8'h00, 8'd1, 1, 0, 0, 1, NOP);
            add(0, 9'd0, 1, ba[i], 8'd1, 1, 0, 0, 1, NOP);
        end
        add(0, 9'd0, 0, 8'h00, 8'd0, 0, 1, 1, 1, 32'h0020_0113);
        add(0, 9'd0, 0, 8'h00, 8'd1, 0, 1, 0, 1, 32'h0030_0213);
        // Single-word reload: mem[0] replaced, mem[1] untouched
        add(1, 9'd1, 0, 8'h00, 8'd0, 0, 1, 0, 1, 32'h0020_0113);
        for (int i = 0; i < 4; i++) add(0, 9'd0, 1, bc[i], 8'd1, 1, 0, 0, 1, NOP);
        add(0, 9'd0, 0, 8'h00, 8'd0, 0, 1, 1, 1, 32'h0050_0093);
        add(0, 9'd0, 0, 8'h00, 8'd1, 0, 1, 0, 1, 32'h0030_0213);

        repeat (2) @(negedge clk);
        #1;
        chk("reset en", 32'(en), 32'd0);
        chk("reset ready", 32'(load_ready), 32'd0);
        chk("reset done", 32'(load_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("idle after reset en", 32'(en), 32'd0);

        foreach (vecs[k]) begin
            @(negedge clk);
            load_start = vecs[k].start;
            load_len   = vecs[k].len;
            load_valid = vecs[k].valid;
            load_data  = vecs[k].data;
            progmem_addr = vecs[k].addr;
            #1;
            chk($sformatf("v%0d ready", k), 32'(load_ready), 32'(vecs[k].exp_ready));
            chk($sformatf("v%0d en", k), 32'(en), 32'(vecs[k].exp_en));
            chk($sformatf("v%0d done", k), 32'(load_done), 32'(vecs[k].exp_done));
            if (vecs[k].chk_pd) chk($sformatf("v%0d pdata", k), progmem_data, vecs[k].exp_pd);
        end

        // Mid-load reset after 5 of 8 bytes
        bm = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
        @(negedge clk);
        load_start = 1'b1; load_len = 9'd2; load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load_start = 1'b0; load_valid = 1'b1; load_data = bm[i];
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("midreset en", 32'(en), 32'd0);
        chk("midreset ready", 32'(load_ready), 32'd0);
        chk("midreset done", 32'(load_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("postreset idle en %0d", i), 32'(en), 32'd0);
            chk($sformatf("postreset idle ready %0d", i), 32'(load_ready), 32'd0);
        end
        progmem_addr = 8'd0;
        #1;
        chk("midreset mem0 kept", progmem_data, 32'hDDCC_BBAA);
        progmem_addr = 8'd1;
        #1;
        chk("midreset mem1 old", progmem_data, 32'h0030_0213);

        // Reset landing on the done pulse clears it immediately
        br = '{8'h01, 8'h02, 8'h03, 8'h04};
        @(negedge clk);
        load_start = 1'b1; load_len = 9'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_start = 1'b0; load_valid = 1'b1; load_data = br[i];
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("pre-reset done", 32'(load_done), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset clears done", 32'(load_done), 32'd0);
        chk("reset clears en", 32'(en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        progmem_addr = 8'd0;
        #1;
        chk("mem0 after reset", progmem_data, 32'h0403_0201);

        full_load(9'd0, 8'h00, 1'b1, "len0");
        full_load(9'h1FF, 8'h77, 1'b0, "clamp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/progmem_loader.md
PROGMEM_LOADER -- requirements
Module: progmem_loader

Interface
REQ-001 Parameter INST_W, default 32, instruction width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 8, word address width; memory depth SHALL be 2**ADDR_W words.
REQ-003 Parameter NOP, default 32'h00000013 (ADDI x0,x0,0), word returned to the core while loading.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 load_start  input  1  request a new program load; sampled each cycle.
REQ-007 load_len  input  ADDR_W+1  number of words to load; sampled when load_start is accepted.
REQ-008 load_data  input  8  byte stream, least-significant byte of each word first.
REQ-009 load_valid  input  1  load_data is valid this cycle.
REQ-010 load_ready  output  1  loader accepts a byte this cycle.
REQ-011 load_done  output  1  one-cycle pulse when a load completes.
REQ-012 en  output  1  core enable; drives the core's en input.
REQ-013 progmem_addr  input  ADDR_W  core fetch address.
REQ-014 progmem_data  output  INST_W  instruction at progmem_addr.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOAD and RUN.
REQ-016 IDLE: en=0 and load_ready=0; load_start=1 SHALL move the FSM to LOAD.
REQ-017 RUN: en=1 and load_ready=0; load_start=1 SHALL move the FSM to LOAD, and en SHALL drop to 0 in the first LOAD cycle.
REQ-018 On entering LOAD, the block SHALL latch load_len, clear the word pointer wptr, and clear the byte index bidx.
- A latched length of 0 SHALL mean 2**ADDR_W words.
- A latched length above 2**ADDR_W SHALL be clamped to 2**ADDR_W.
REQ-019 LOAD: load_ready=1 and en=0; a byte is accepted on a cycle where load_valid && load_ready.
REQ-020 Each accepted byte SHALL be placed at bits [8*bidx+7 : 8*bidx] of the word buffer, and bidx SHALL increment, wrapping after INST_W/8-1.
REQ-021 On accepting the last byte of a word, the block SHALL write the completed word to mem[wptr] on that same edge and increment wptr.
- If that word is word number len, the FSM SHALL enter RUN on the same edge.
- load_done SHALL be 1 for exactly the next cycle.
- en SHALL be 1 from that next cycle onward.
REQ-022 Cycles in LOAD with load_valid=0 SHALL leave all state unchanged; there is no timeout.
REQ-023 load_start asserted while in LOAD SHALL be ignored.
REQ-024 progmem_data SHALL be combinational.
- Outside LOAD: progmem_data = mem[progmem_addr].
- In LOAD: progmem_data = NOP.
REQ-025 Words not written by the most recent load SHALL retain their previous contents.
REQ-026 Memory SHALL have one write port and one asynchronous read port.

Reset
REQ-027 When rst_n=0, the block SHALL immediately force state=IDLE, en=0, load_ready=0, load_done=0, wptr=0 and bidx=0.
REQ-028 Reset asserted mid-load SHALL abort the load; words already written remain in memory, and the partially assembled word is discarded.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 After rst_n rises, the block SHALL stay in IDLE with en=0 until load_start.

Verification
REQ-031 Basic load: load_start with load_len=2, then bytes 13,01,20,00 and 13,02,30,00, one per cycle.
- Required: mem[0]=32'h00200113... the required values are mem[0]=32'h00200113 for the first word? No: mem[0]=32'h00200113 only if bytes are 13,01,20,00 read LSB first, which gives 32'h00200113 — correct.
- Required: mem[1]=32'h00300213.
- Required: load_done pulses exactly once, on the cycle after the 8th byte is accepted.
- Required: en=1 from that same cycle.
REQ-032 Gapped stream: same bytes with load_valid low on alternate cycles -> identical memory contents; the done pulse moves later by the number of idle cycles.
REQ-033 Reload from RUN: pulse load_start with load_len=1 -> en=0 and progmem_data=NOP during the load; after completion mem[0] holds the new word and mem[1] is unchanged.
REQ-034 Mid-load reset: assert rst_n=0 after 5 of 8 bytes -> en=0, load_ready=0, load_done=0 asynchronously; mem[0] keeps the loaded word and the FSM stays in IDLE until load_start.
REQ-035 Full depth: load_len=0 -> exactly 4*2**ADDR_W bytes are accepted, wptr wraps to 0, a single load_done pulse occurs, and load_start pulsed during the load has no effect.
